// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sequencing commands onto a shared combinational ALU
module alu_arbiter #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req0_valid,
  input  logic [NB_DATA-1:0] i_req0_a,
  input  logic [NB_DATA-1:0] i_req0_b,
  input  logic [NB_OP-1:0]   i_req0_op,
  output logic               o_req0_ready,
  input  logic               i_req1_valid,
  input  logic [NB_DATA-1:0] i_req1_a,
  input  logic [NB_DATA-1:0] i_req1_b,
  input  logic [NB_OP-1:0]   i_req1_op,
  output logic               o_req1_ready,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_res,
  input  logic               i_alu_carry,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic               o_rsp_id,
  output logic [NB_DATA-1:0] o_rsp_res,
  output logic               o_rsp_carry,
  output logic               o_rsp_err,
  output logic               o_busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);

  state_t               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic [NB_DATA-1:0]   alu_a_q, alu_a_d;
  logic [NB_DATA-1:0]   alu_b_q, alu_b_d;
  logic [NB_OP-1:0]     alu_op_q, alu_op_d;
  logic                 id_q, id_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [NB_DATA-1:0]   rsp_res_q, rsp_res_d;
  logic                 rsp_carry_q, rsp_carry_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 grant0, grant1;
  logic                 op_legal;

  // The pointer only breaks ties; a lone requester always wins.
  assign grant0 = i_req0_valid & (~i_req1_valid | ~ptr_q);
  assign grant1 = i_req1_valid & (~i_req0_valid |  ptr_q);

  assign o_req0_ready = i_rst_n & (state_q == IDLE) & grant0;
  assign o_req1_ready = i_rst_n & (state_q == IDLE) & grant1;

  always_comb begin
    op_legal = 1'b0;
    case (alu_op_q)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_res_d   = rsp_res_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (o_req0_ready || o_req1_ready) begin
          state_d  = EXEC;
          id_d     = o_req1_ready;
          ptr_d    = o_req0_ready;
          alu_a_d  = o_req1_ready ? i_req1_a  : i_req0_a;
          alu_b_d  = o_req1_ready ? i_req1_b  : i_req0_b;
          alu_op_d = o_req1_ready ? i_req1_op : i_req0_op;
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_res_d   = op_legal ? i_alu_res : '0;
        rsp_carry_d = op_legal & i_alu_carry;
        rsp_err_d   = ~op_legal;
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_alu_a     = alu_a_q;
  assign o_alu_b     = alu_b_q;
  assign o_alu_op    = alu_op_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = id_q;
  assign o_rsp_res   = rsp_res_q;
  assign o_rsp_carry = rsp_carry_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with an attached ALU model
module tb_alu_arbiter;

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic       carry;
    logic       err;
  } rsp_t;

  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100, OR_ = 6'b100101;
  localparam logic [5:0] XOR_ = 6'b100110, SRA = 6'b000011, SRL = 6'b000010, NOR_ = 6'b100111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0, rr = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [5:0] op0 = '0, op1 = '0;
  logic       ready0, ready1;
  logic [7:0] alu_a, alu_b, alu_res;
  logic [5:0] alu_op;
  logic       alu_carry;
  logic       rsp_valid, rsp_id, rsp_carry, rsp_err, busy;
  logic [7:0] rsp_res;

  int   errors = 0;
  int   checks = 0;
  rsp_t exp_q[$];
  logic m_ptr = 1'b0;
  int   m_ph = 0;
  logic [5:0] legal_ops [8] = '{ADD, SUB, AND_, OR_, XOR_, SRA, SRL, NOR_};

  always #5 clk = ~clk;

  alu_arbiter #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_op(op0), .o_req0_ready(ready0),
    .i_req1_valid(v1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_op(op1), .o_req1_ready(ready1),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_res(alu_res), .i_alu_carry(alu_carry),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rr), .o_rsp_id(rsp_id),
    .o_rsp_res(rsp_res), .o_rsp_carry(rsp_carry), .o_rsp_err(rsp_err), .o_busy(busy)
  );

  // Illegal opcodes return junk so a design that forwards it gets caught.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      ADD:     return {1'b0, a} + {1'b0, b};
      SUB:     return {1'b0, a} - {1'b0, b};
      AND_:    return {1'b0, a & b};
      OR_:     return {1'b0, a | b};
      XOR_:    return {1'b0, a ^ b};
      NOR_:    return {1'b0, ~(a | b)};
      SRA:     return {1'b0, 8'($signed(a) >>> b[2:0])};
      SRL:     return {1'b0, a >> b[2:0]};
      default: return 9'h1A5;
    endcase
  endfunction

  always_comb {alu_carry, alu_res} = alu_fn(alu_a, alu_b, alu_op);

  function automatic rsp_t predict(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    rsp_t r;
    logic [8:0] full;
    r.id = id;
    if (op inside {ADD, SUB, AND_, OR_, XOR_, SRA, SRL, NOR_}) begin
      full = alu_fn(a, b, op);
      r.res = full[7:0];
      r.carry = full[8];
      r.err = 1'b0;
    end else begin
      r.res = 8'h00;
      r.carry = 1'b0;
      r.err = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, check control outputs against the model, advance the model.
  task automatic cycle(input logic iv0, input logic [7:0] ia0, input logic [7:0] ib0, input logic [5:0] iop0,
                       input logic iv1, input logic [7:0] ia1, input logic [7:0] ib1, input logic [5:0] iop1,
                       input logic irr, output int gnt);
    @(posedge clk);
    #2;
    v0 = iv0; a0 = ia0; b0 = ib0; op0 = iop0;
    v1 = iv1; a1 = ia1; b1 = ib1; op1 = iop1;
    rr = irr;
    #1;
    chk("busy", 32'(busy), 32'(m_ph != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_ph == 2));
    gnt = -1;
    if (m_ph == 0) begin
      if (iv0 && (!iv1 || m_ptr == 1'b0)) gnt = 0;
      else if (iv1) gnt = 1;
    end
    chk("ready0", 32'(ready0), 32'(gnt == 0));
    chk("ready1", 32'(ready1), 32'(gnt == 1));
    if (gnt == 0) begin
      exp_q.push_back(predict(1'b0, ia0, ib0, iop0));
      m_ptr = 1'b1;
      m_ph = 1;
    end else if (gnt == 1) begin
      exp_q.push_back(predict(1'b1, ia1, ib1, iop1));
      m_ptr = 1'b0;
      m_ph = 1;
    end else if (m_ph == 1) begin
      m_ph = 2;
    end else if (m_ph == 2 && irr) begin
      m_ph = 0;
    end
  endtask

  task automatic idle(input int n, input logic irr);
    int g;
    repeat (n) cycle(1'b0, 8'h00, 8'h00, 6'h00, 1'b0, 8'h00, 8'h00, 6'h00, irr, g);
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    m_ph = 0;
    m_ptr = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_alu", {8'h0, alu_a, alu_b, 2'b0, alu_op}, 32'h0);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_carry, rsp_err, busy, ready0, ready1, rsp_res}, 32'h0);
  endtask

  // Response monitor: pops on each handshake and watches stability under backpressure.
  logic       held = 1'b0;
  logic [10:0] prev_rsp = '0;
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid) begin
      if (held) chk("rsp_stable", 32'({rsp_id, rsp_carry, rsp_err, rsp_res}), 32'(prev_rsp));
      if (rr) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_res", 32'(rsp_res), 32'(e.res));
          chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      held <= !rr;
      prev_rsp <= {rsp_id, rsp_carry, rsp_err, rsp_res};
    end else begin
      held <= 1'b0;
    end
  end

  initial begin
    int g;
    logic       pv [2];
    logic [7:0] pa [2];
    logic [7:0] pb [2];
    logic [5:0] po [2];

    do_reset(2);

    cycle(1'b1, 8'hFF, 8'h01, ADD, 1'b0, 8'h00, 8'h00, 6'h00, 1'b1, g);
    idle(3, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 6'h00, 1'b1, 8'h05, 8'h07, SUB, 1'b1, g);
    idle(3, 1'b1);

    repeat (12) cycle(1'b1, 8'h12, 8'h34, XOR_, 1'b1, 8'h56, 8'h78, OR_, 1'b1, g);
    idle(3, 1'b1);

    cycle(1'b1, 8'hAA, 8'h55, 6'b111111, 1'b0, 8'h00, 8'h00, 6'h00, 1'b1, g);
    idle(2, 1'b1);
    cycle(1'b1, 8'h81, 8'h02, SRA, 1'b0, 8'h00, 8'h00, 6'h00, 1'b1, g);
    chk("after_illegal_grant", 32'(g), 32'(0));
    idle(3, 1'b1);

    cycle(1'b1, 8'hF0, 8'h3C, AND_, 1'b0, 8'h00, 8'h00, 6'h00, 1'b0, g);
    idle(6, 1'b0);
    idle(3, 1'b1);

    do_reset(2);
    cycle(1'b0, 8'h00, 8'h00, 6'h00, 1'b1, 8'h0F, 8'h01, NOR_, 1'b0, g);
    idle(3, 1'b0);
    do_reset(1);
    idle(2, 1'b1);
    cycle(1'b1, 8'h40, 8'h03, SRL, 1'b1, 8'h40, 8'h03, SRA, 1'b1, g);
    chk("post_reset_ptr", 32'(g), 32'(0));
    idle(3, 1'b1);

    for (int p = 0; p < 2; p++) begin
      pv[p] = 1'b0; pa[p] = '0; pb[p] = '0; po[p] = '0;
    end
    repeat (400) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && ($urandom % 3 == 0)) begin
          pv[p] = 1'b1;
          pa[p] = 8'($urandom);
          pb[p] = 8'($urandom);
          po[p] = ($urandom % 8 == 0) ? 6'($urandom) : legal_ops[$urandom % 8];
        end else if (pv[p] && ($urandom % 10 == 0)) begin
          pv[p] = 1'b0;
        end
      end
      cycle(pv[0], pa[0], pb[0], po[0], pv[1], pa[1], pb[1], po[1], ($urandom % 4) != 0, g);
      if (g >= 0) pv[g] = 1'b0;
    end
    idle(12, 1'b1);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, giving the operand and result width.
REQ-002 The block SHALL have parameter NB_OP, default 6, giving the opcode width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 Port i_clk SHALL be an input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 Port i_rst_n SHALL be an input, 1 bit: synchronous active-low reset.
REQ-006 Ports i_req0_valid / i_req1_valid SHALL be inputs, 1 bit each: requester 0/1 has a command.
REQ-007 Ports i_req0_a, i_req0_b / i_req1_a, i_req1_b SHALL be inputs, NB_DATA bits each: operands.
REQ-008 Ports i_req0_op / i_req1_op SHALL be inputs, NB_OP bits each: ALU opcode.
REQ-009 Ports o_req0_ready / o_req1_ready SHALL be outputs, 1 bit each: command accepted this cycle.
REQ-010 Ports o_alu_a, o_alu_b SHALL be outputs, NB_DATA bits each, and o_alu_op an output, NB_OP bits: drive the shared ALU.
REQ-011 Ports i_alu_res (NB_DATA bits) and i_alu_carry (1 bit) SHALL be inputs: the combinational ALU result.
REQ-012 Port o_rsp_valid SHALL be an output, 1 bit: response available.
REQ-013 Port i_rsp_ready SHALL be an input, 1 bit: consumer accepts the response.
REQ-014 Port o_rsp_id SHALL be an output, 1 bit: requester that owns the response.
REQ-015 Ports o_rsp_res (NB_DATA bits), o_rsp_carry (1 bit) and o_rsp_err (1 bit) SHALL be outputs: registered result, carry and illegal-opcode flag.
REQ-016 Port o_busy SHALL be an output, 1 bit: high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-018 IDLE SHALL go to EXEC on an accepted command; EXEC SHALL always go to RESP; RESP SHALL go to IDLE on o_rsp_valid & i_rsp_ready, else remain in RESP.
REQ-019 Readies SHALL be combinational and asserted only in IDLE, for at most one port: the winner among the ports with valid high.
REQ-020 A handshake is valid & ready in the same cycle; on it the block SHALL latch a, b, op and the port id.
REQ-021 Arbitration SHALL be round-robin through a priority pointer, which is 0 after reset.
REQ-022 When both valids are high, the pointed port SHALL win; when only one is high, that port SHALL win regardless of the pointer.
REQ-023 After each grant the pointer SHALL move to the other port.
REQ-024 In EXEC, o_alu_a, o_alu_b and o_alu_op SHALL carry the latched command; at the end of EXEC, i_alu_res and i_alu_carry SHALL be registered into o_rsp_res and o_rsp_carry.
REQ-025 In every other state, o_alu_a, o_alu_b and o_alu_op SHALL hold their last value.
REQ-026 Legal opcodes SHALL be exactly: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
REQ-027 For an illegal opcode, the command SHALL still be sequenced, with o_rsp_err=1, o_rsp_res=0 and o_rsp_carry=0.
REQ-028 For a legal opcode, o_rsp_err SHALL be 0.
REQ-029 Latency: for a handshake in cycle T, EXEC SHALL be cycle T+1 and o_rsp_valid SHALL be 1 from cycle T+2.
REQ-030 Minimum issue interval SHALL be 3 cycles; no new command SHALL be accepted while busy.
REQ-031 While o_rsp_valid=1 and i_rsp_ready=0, all o_rsp_* outputs SHALL hold stable.
REQ-032 o_rsp_valid SHALL deassert in the cycle after the response handshake.
REQ-033 A requester's valid dropping while not granted SHALL have no effect: no state change and no pointer change.

Reset
REQ-034 On a clock edge with i_rst_n=0, the block SHALL enter IDLE, set the pointer to 0, and set all outputs to 0.
REQ-035 The outputs reset to 0 SHALL be: readies, o_alu_a, o_alu_b, o_alu_op, o_rsp_valid, o_rsp_id, o_rsp_res, o_rsp_carry, o_rsp_err and o_busy.
REQ-036 A reset in EXEC or RESP SHALL discard the in-flight command with no response issued.

Verification
REQ-037 Port 0: ADD a=0xFF, b=0x01 (ALU model attached) -> o_rsp_valid at T+2, id=0, res=0x00, carry=1, err=0.
REQ-038 Port 1: SUB a=0x05, b=0x07 -> id=1, res=0xFE, carry=1, err=0.
REQ-039 Both ports valid continuously from reset release, i_rsp_ready=1 -> grants alternate 0,1,0,1; one grant per 3 cycles.
REQ-040 Port 0 op=111111 -> err=1, res=0x00, carry=0; the next command is accepted normally.
REQ-041 AND 0xF0,0x3C with i_rsp_ready=0 for 5 cycles -> res=0x30 held stable with valid=1 throughout; IDLE the cycle after the handshake.
REQ-042 i_rst_n=0 for one cycle during RESP -> o_rsp_valid=0 next cycle, no response for that command, pointer=0.
